// File: rtl/terminal_pkg.sv
`default_nettype none
// ============================================================================
// Module      : terminal_pkg
// Description : Shared constants, arbiter state encoding and requester IDs
//               for the terminal text-port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package terminal_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;
    localparam int COLS   = 80;
    localparam int ROWS   = 30;
    localparam int CELLS  = COLS * ROWS;

    localparam logic [DATA_W-1:0] CLEAR_CHAR = 8'h20;

    // Arbiter states; CLEAR only reachable when the clear engine is built in
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    // Requester IDs carried in the read-tag pipeline and the last-winner flag
    localparam logic REQ_DBG = 1'b0;
    localparam logic REQ_CPU = 1'b1;

endpackage

`default_nettype wire

// File: rtl/terminal_clear_engine.sv
`default_nettype none
// ============================================================================
// Module      : terminal_clear_engine
// Description : Cell counter for the screen clear. Restarts from cell 0 on
//               i_start, advances once per cycle while i_run is high and
//               flags the final cell with o_done. Only instantiated when
//               TERMINAL_ARB_CLEAR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module terminal_clear_engine
    import terminal_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_run,
    output logic [ADDR_W-1:0] o_count,
    output logic              o_done,
    output logic              o_busy
);

    localparam logic [ADDR_W-1:0] c_LAST_CELL = ADDR_W'(CELLS - 1);

    logic [ADDR_W-1:0] r_count;

    // Cell counter: cleared on start, steps each running cycle, never wraps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_start) begin
            r_count <= '0;
        end else if (i_run) begin
            r_count <= o_done ? '0 : r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_done  = i_run && (r_count == c_LAST_CELL);
    assign o_busy  = i_run;

endmodule

`default_nettype wire

// File: rtl/terminal_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : terminal_arbiter
// Description : Round-robin arbiter sharing the terminal text-buffer port
//               between the debugger (dbg) and the CPU console (cpu).
//               Combinational grant, registered memory port, 2-stage read
//               tag pipeline. Optional screen-clear engine is built in when
//               the macro TERMINAL_ARB_CLEAR_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module terminal_arbiter
    import terminal_pkg::*;
(
    input  logic              clock,
    input  logic              reset,

    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,

    input  logic              clear_start,
    output logic              clear_busy,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              w_idle;
    logic              w_in_clear;
    logic [ADDR_W-1:0] w_clr_count;

    logic              r_last_winner;
    logic              w_launch;
    logic              w_launch_id;
    logic              r_tag1_vld;
    logic              r_tag1_id;
    logic              r_tag2_vld;
    logic              r_tag2_id;

`ifdef TERMINAL_ARB_CLEAR_EN
    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       w_clr_start;
    logic       w_clr_done;

    assign w_idle      = (r_state == IDLE);
    assign w_in_clear  = (r_state == CLEAR);
    assign w_clr_start = w_idle && clear_start;

    terminal_clear_engine u_clear_engine (
        .clk     (clock),
        .rst     (reset),
        .i_start (w_clr_start),
        .i_run   (w_in_clear),
        .o_count (w_clr_count),
        .o_done  (w_clr_done),
        .o_busy  (clear_busy)
    );

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: start only from IDLE, leave CLEAR after the last cell
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (clear_start) w_state_nxt = CLEAR;
            CLEAR:   if (w_clr_done)  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end
`else
    logic w_unused_clear_start;

    assign w_idle               = 1'b1;
    assign w_in_clear           = 1'b0;
    assign w_clr_count          = '0;
    assign clear_busy           = 1'b0;
    assign w_unused_clear_start = clear_start;
`endif

    // Grant: sole requester wins; on contention the one not granted last wins
    always_comb begin
        dbg_gnt = 1'b0;
        cpu_gnt = 1'b0;
        if (w_idle) begin
            if (dbg_req && (!cpu_req || (r_last_winner == REQ_CPU))) begin
                dbg_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
    end

    // Last-winner flag, updated only when a grant is given
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_last_winner <= REQ_CPU;
        end else if (dbg_gnt) begin
            r_last_winner <= REQ_DBG;
        end else if (cpu_gnt) begin
            r_last_winner <= REQ_CPU;
        end
    end

    // Registered memory port: clear write, granted access, or idle (we = 0)
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (w_in_clear) begin
            mem_we    <= 1'b1;
            mem_addr  <= w_clr_count;
            mem_wdata <= CLEAR_CHAR;
        end else if (dbg_gnt) begin
            mem_we    <= dbg_we;
            mem_addr  <= dbg_addr;
            mem_wdata <= dbg_wdata;
        end else if (cpu_gnt) begin
            mem_we    <= cpu_we;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
        end else begin
            mem_we    <= 1'b0;
        end
    end

    assign w_launch    = (dbg_gnt && !dbg_we) || (cpu_gnt && !cpu_we);
    assign w_launch_id = cpu_gnt ? REQ_CPU : REQ_DBG;

    // Read-tag pipeline: stage 2 lines up with RAM data one cycle after mem_addr
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_tag1_vld <= 1'b0;
            r_tag1_id  <= REQ_DBG;
            r_tag2_vld <= 1'b0;
            r_tag2_id  <= REQ_DBG;
        end else begin
            r_tag1_vld <= w_launch;
            r_tag1_id  <= w_launch_id;
            r_tag2_vld <= r_tag1_vld;
            r_tag2_id  <= r_tag1_id;
        end
    end

    assign dbg_rvalid = r_tag2_vld && (r_tag2_id == REQ_DBG);
    assign cpu_rvalid = r_tag2_vld && (r_tag2_id == REQ_CPU);
    assign dbg_rdata  = mem_rdata;
    assign cpu_rdata  = mem_rdata;

endmodule

`default_nettype wire

// File: tb/tb_terminal_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_terminal_arbiter
// Description : Directed self-checking bench for terminal_arbiter with a
//               synchronous 1-cycle-latency RAM model on the text port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_terminal_arbiter;

    logic        clk;
    logic        reset;
    logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid;
    logic [11:0] dbg_addr;
    logic [7:0]  dbg_wdata, dbg_rdata;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata, cpu_rdata;
    logic        clear_start, clear_busy;
    logic [11:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;

    logic [7:0]  ram [0:4095];
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [7:0]  bd_data;

    int n_checks = 0;
    int n_fail   = 0;

    terminal_arbiter dut (
        .clock       (clk),
        .reset       (reset),
        .dbg_req     (dbg_req),
        .dbg_we      (dbg_we),
        .dbg_addr    (dbg_addr),
        .dbg_wdata   (dbg_wdata),
        .dbg_gnt     (dbg_gnt),
        .dbg_rvalid  (dbg_rvalid),
        .dbg_rdata   (dbg_rdata),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_gnt     (cpu_gnt),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous RAM, read-before-write, with a backdoor preload port
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(negedge clk);
    endtask

    initial begin
        int          cnt;
        int          bad;
        logic        gnt_seen;
        logic [5:0]  exp_dbg;
        logic [11:0] a;

        clk = 0; reset = 1;
        dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_wdata = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        clear_start = 0; bd_we = 0; bd_addr = '0; bd_data = '0;

        repeat (2) @(negedge clk);
        preload(12'h050, 8'h41);
        preload(12'h123, 8'h5C);
        preload(12'h960, 8'h77);
        bd_we = 1'b0;
        reset = 1'b0;
        @(negedge clk); #1;

        // Reset state
        check("rst_dbg_gnt", dbg_gnt, 0);
        check("rst_cpu_gnt", cpu_gnt, 0);
        check("rst_rvalid", {dbg_rvalid, cpu_rvalid}, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_busy", clear_busy, 0);

        // Contention: both write, grants alternate starting with dbg
        exp_dbg = 6'b010101;
        @(negedge clk);
        dbg_req = 1; cpu_req = 1; dbg_we = 1; cpu_we = 1;
        for (int i = 0; i < 6; i++) begin
            dbg_addr  = 12'((i + 1) / 2 * 2);
            dbg_wdata = 8'hD0 + 8'((i + 1) / 2 * 2);
            cpu_addr  = 12'(i / 2 * 2 + 1);
            cpu_wdata = 8'hC0 + 8'(i / 2 * 2 + 1);
            #1;
            check("cont_dbg_gnt", dbg_gnt, exp_dbg[i]);
            check("cont_cpu_gnt", cpu_gnt, !exp_dbg[i]);
            if (i > 0) begin
                check("cont_mem_we", mem_we, 1);
                check("cont_mem_addr", mem_addr, i - 1);
                check("cont_mem_wdata", mem_wdata, exp_dbg[i-1] ? 32'hD0 + i - 1 : 32'hC0 + i - 1);
            end
            check("cont_rvalid", {dbg_rvalid, cpu_rvalid}, 0);
            @(negedge clk);
        end
        dbg_req = 0; cpu_req = 0;
        #1;
        check("cont_last_we", mem_we, 1);
        check("cont_last_addr", mem_addr, 12'h005);
        check("cont_last_wdata", mem_wdata, 8'hC5);
        @(negedge clk); #1;
        check("idle_mem_we", mem_we, 0);
        check("idle_mem_addr_hold", mem_addr, 12'h005);

        // Single dbg read of 0x050
        @(negedge clk);
        dbg_req = 1; dbg_we = 0; dbg_addr = 12'h050;
        #1;
        check("rd_dbg_gnt", dbg_gnt, 1);
        check("rd_cpu_gnt", cpu_gnt, 0);
        @(negedge clk);
        dbg_req = 0;
        #1;
        check("rd_mem_addr", mem_addr, 12'h050);
        check("rd_mem_we", mem_we, 0);
        check("rd_early_rvalid", dbg_rvalid, 0);
        @(negedge clk); #1;
        check("rd_dbg_rvalid", dbg_rvalid, 1);
        check("rd_dbg_rdata", dbg_rdata, 8'h41);
        check("rd_cpu_rvalid", cpu_rvalid, 0);
        @(negedge clk); #1;
        check("rd_rvalid_pulse", dbg_rvalid, 0);

        // cpu read back of a contention write (addr 3 = 0xC3)
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h003;
        #1;
        check("cpurd_gnt", cpu_gnt, 1);
        @(negedge clk);
        cpu_req = 0;
        @(negedge clk); #1;
        check("cpurd_rvalid", cpu_rvalid, 1);
        check("cpurd_rdata", cpu_rdata, 8'hC3);
        check("cpurd_dbg_rvalid", dbg_rvalid, 0);

`ifdef TERMINAL_ARB_CLEAR_EN
        // In-flight cpu read followed by a full clear
        @(negedge clk);
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h123;
        #1;
        check("inflt_cpu_gnt", cpu_gnt, 1);
        @(negedge clk);
        cpu_req = 0; clear_start = 1;
        #1;
        check("inflt_busy_pre", clear_busy, 0);
        @(negedge clk);
        clear_start = 0;
        dbg_req = 1; dbg_we = 0; dbg_addr = 12'h960;
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h000;
        #1;
        check("inflt_cpu_rvalid", cpu_rvalid, 1);
        check("inflt_cpu_rdata", cpu_rdata, 8'h5C);
        cnt = 0; gnt_seen = 0;
        while (clear_busy && cnt < 5000) begin
            if (dbg_gnt || cpu_gnt) gnt_seen = 1;
            if (cnt == 1) begin
                check("clr_cell0_we", mem_we, 1);
                check("clr_cell0_addr", mem_addr, 0);
                check("clr_cell0_wdata", mem_wdata, 8'h20);
            end
            if (cnt == 2) check("clr_cell1_addr", mem_addr, 1);
            cnt++;
            @(negedge clk); #1;
        end
        check("clr_busy_cycles", cnt, 2400);
        check("clr_no_gnt", gnt_seen, 0);
        check("clr_last_addr", mem_addr, 12'h95F);
        check("clr_last_we", mem_we, 1);
        check("clr_post_dbg_gnt", dbg_gnt, 1);
        check("clr_post_cpu_gnt", cpu_gnt, 0);
        @(negedge clk);
        dbg_req = 0; cpu_req = 0;
        @(negedge clk); #1;
        check("clr_cell2400_rd", dbg_rvalid, 1);
        check("clr_cell2400_data", dbg_rdata, 8'h77);
        bad = 0;
        for (int k = 0; k < 2400; k++) begin
            a = 12'(k);
            if (ram[a] !== 8'h20) bad++;
        end
        check("clr_cells_blank", bad, 0);

        // Start while busy, with a request in the start cycle
        @(negedge clk);
        clear_start = 1; dbg_req = 1; dbg_we = 1; dbg_addr = 12'h961; dbg_wdata = 8'h99;
        #1;
        check("sb_same_cycle_gnt", dbg_gnt, 1);
        @(negedge clk);
        clear_start = 0; dbg_req = 0;
        #1;
        check("sb_req_write_addr", mem_addr, 12'h961);
        check("sb_req_write_data", mem_wdata, 8'h99);
        cnt = 0;
        while (clear_busy && cnt < 5000) begin
            clear_start = (cnt == 100);
            cnt++;
            @(negedge clk); #1;
        end
        clear_start = 0;
        check("sb_busy_cycles", cnt, 2400);

        // Reset at cycle 500 of a clear
        @(negedge clk);
        clear_start = 1;
        @(negedge clk);
        clear_start = 0;
        #1;
        cnt = 0;
        while (clear_busy && cnt < 500) begin
            cnt++;
            @(negedge clk); #1;
        end
        check("rstmid_reached", cnt, 500);
        reset = 1;
        #1;
        check("rstmid_busy", clear_busy, 0);
        check("rstmid_mem_we", mem_we, 0);
        check("rstmid_mem_addr", mem_addr, 0);
        check("rstmid_mem_wdata", mem_wdata, 0);
        check("rstmid_gnt", {dbg_gnt, cpu_gnt}, 0);
        check("rstmid_rvalid", {dbg_rvalid, cpu_rvalid}, 0);
        @(negedge clk);
        reset = 0;
        @(negedge clk); #1;
        check("rstmid_after_busy", clear_busy, 0);
        dbg_req = 1; cpu_req = 1; dbg_we = 0; cpu_we = 0;
        #1;
        check("rstmid_dbg_first", dbg_gnt, 1);
        check("rstmid_cpu_second", cpu_gnt, 0);
        @(negedge clk);
        dbg_req = 0; cpu_req = 0;
`else
        // Clear engine absent: start ignored, busy stays low, grants unaffected
        @(negedge clk);
        clear_start = 1; dbg_req = 1; dbg_we = 1; dbg_addr = 12'h200; dbg_wdata = 8'h5A;
        #1;
        check("noclr_dbg_gnt", dbg_gnt, 1);
        @(negedge clk);
        clear_start = 0; dbg_req = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h201; cpu_wdata = 8'h6B;
        #1;
        check("noclr_busy", clear_busy, 0);
        check("noclr_mem_addr", mem_addr, 12'h200);
        check("noclr_cpu_gnt", cpu_gnt, 1);
        @(negedge clk);
        cpu_req = 0;
        #1;
        check("noclr_busy_later", clear_busy, 0);
        check("noclr_mem_wdata", mem_wdata, 8'h6B);
`endif

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/terminal_arbiter.md
# terminal_arbiter

Shares the terminal text-buffer port (12-bit address, 8-bit character) between the on-screen debugger and a CPU memory-mapped console requester. Arbitration is round-robin with a req/gnt handshake, and the registered memory port is driven one access per cycle. A built-in clear engine, compiled in by a macro, can blank the 80×30 screen. The block sits between the requesters and the Terminal text port, all in one clock domain.

## Interface
- ADDR_W, 12, text-buffer address width
- DATA_W, 8, character width
- CELLS, 2400, number of cells cleared (80×30)
- CLEAR_CHAR, 8'h20, character written by the clear engine

- clock  in  1  single clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high
- dbg_req / cpu_req  in  1  access request; held with its fields until granted
- dbg_we / cpu_we  in  1  1 = write, 0 = read
- dbg_addr / cpu_addr  in  ADDR_W  cell address
- dbg_wdata / cpu_wdata  in  DATA_W  write character
- dbg_gnt / cpu_gnt  out  1  combinational grant; the access is accepted this cycle
- dbg_rvalid / cpu_rvalid  out  1  read data valid pulse
- dbg_rdata / cpu_rdata  out  DATA_W  pass-through of mem_rdata
- clear_start  in  1  single-cycle clear request
- clear_busy  out  1  clear engine running
- mem_addr  out  ADDR_W  registered text-port address
- mem_we  out  1  registered write strobe
- mem_wdata  out  DATA_W  registered write data
- mem_rdata  in  DATA_W  text-port read data; synchronous RAM, 1-cycle latency

## Operation
- States: IDLE and CLEAR.
- **IDLE arbitration:**
  - With only one request, that requester is granted.
  - With both requesting, the requester not granted last time wins.
  - The last-winner flag updates only on a grant.
- **Grant is combinational** from the req inputs, the state and the last-winner flag. The winner's we, addr and wdata are registered into mem_* at the edge closing the grant cycle.
- **Idle port:** with no grant, mem_we is registered as 0 and mem_addr/mem_wdata hold their previous values.
- **Read tags:** a granted read launches a 2-stage tag pipeline that carries the requester ID. The matching rvalid pulses for exactly 1 cycle. Writes produce no rvalid.
- **Clear start:** clear_start sampled high in IDLE moves the FSM to CLEAR with cell counter = 0.
- **CLEAR:**
  - Both grants are forced low.
  - Each cycle the block registers mem_we = 1, mem_addr = counter, mem_wdata = CLEAR_CHAR, then increments the counter.
  - When counter = CELLS−1, that write is issued and the FSM returns to IDLE.
- **Reads in flight** when a clear starts still complete, with their rvalid delivered normally.
- **clear_start while busy** is ignored; the clear does not restart.
- **Reset mid-clear:** the FSM goes to IDLE and the counter returns to 0. Cells already written stay written; no resume.
- **Counter** is ADDR_W bits wide and never wraps, because CELLS ≤ 2^ADDR_W.

## Timing
- Reset values:
  - gnt, rvalid, mem_we, clear_busy = 0
  - mem_addr, mem_wdata, tag pipeline = 0
  - last winner = cpu, so dbg wins the first contention
- Access granted in cycle N: mem_* are valid in cycle N+1. For a read, mem_rdata and rvalid are valid in cycle N+2.
- Throughput is 1 access per cycle. Two requesters held high continuously alternate grants every cycle.
- clear_start sampled at edge E:
  - clear_busy is high for exactly CELLS cycles starting at E.
  - The write of cell k appears on mem_* in cycle E+1+k.
  - The first IDLE grant is possible in the cycle after busy drops.
- clear_start and a request in the same cycle: the request is granted that cycle, since the FSM is still IDLE, and the clear begins on the next cycle.

## Configuration
- TERMINAL_ARB_CLEAR_EN defined: the clear engine and the CLEAR state are present as described above.
- Not defined:
  - The clear_start and clear_busy ports remain.
  - clear_start is ignored and clear_busy is tied to 0.
  - The FSM is reduced to IDLE only, and no counter logic is synthesized.

## Structure
- The shared package `terminal_pkg` holds:
  - ADDR_W, DATA_W
  - COLS = 80, ROWS = 30, CELLS = COLS×ROWS
  - CLEAR_CHAR
  - the arbiter state enum (IDLE, CLEAR)
  - the requester-ID encoding (DBG = 0, CPU = 1)
- Sub-module `terminal_clear_engine` (counter, busy, done) lives inside the `ifdef`. Arbitration and the read-tag pipeline live in the top module.

## Test plan
- **Single read:** dbg read of addr 12'h050 with RAM[0x50] = 8'h41. dbg_gnt is high in the same cycle, mem_addr = 0x050 the next cycle, and dbg_rvalid with dbg_rdata = 8'h41 two cycles after the grant. cpu_rvalid stays 0.
- **Contention:** both requesters hold req for 6 cycles (writes to 0x000–0x005). Grants go dbg, cpu, dbg, cpu, dbg, cpu, and mem_we is high for 6 consecutive cycles.
- **Full clear:** pulse clear_start. clear_busy is high for 2400 cycles and no grant occurs during it. Cells 0..2399 read back 8'h20; cell 2400 is unchanged.
- **Start while busy:** a second clear_start at cycle 100 of a clear causes no restart, and busy still totals 2400 cycles.
- **Reset mid-clear:** assert reset at cycle 500 of a clear. All outputs are 0 immediately. After release, busy = 0 and the first contended grant goes to dbg.
- **In-flight read:** a cpu read granted one cycle before the clear starts still gets cpu_rvalid with the pre-clear data.
